// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_DR   = 2'd2
    } rsp_src_t;

    localparam logic [31:0] MEM_PUTC = 32'h8000_001c;
    localparam logic [31:0] MEM_EXIT = 32'h8000_002c;
    localparam int          STARVE_W = 3;

endpackage

// File: rtl/mem_arb_sel.sv
// mem_arb_sel: one-hot grant selection (dw > dr > if) with fetch anti-starvation.
module mem_arb_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_if_req,
    input  logic i_dr_req,
    input  logic i_dw_req,
    output logic o_if_gnt,
    output logic o_dr_gnt,
    output logic o_dw_gnt
);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_if_win;

    // fetch overrides data requests once it has waited through STARVE_MAX data grants
    always_comb begin
        w_if_win = i_if_req && (r_starve_cnt == STARVE_W'(STARVE_MAX));
        o_dw_gnt = i_dw_req && !w_if_win;
        o_dr_gnt = i_dr_req && !i_dw_req && !w_if_win;
        o_if_gnt = i_if_req && (w_if_win || (!i_dw_req && !i_dr_req));
    end

    // saturating count of data grants taken while fetch is waiting
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            r_starve_cnt <= '0;
        else if (!i_if_req || o_if_gnt)
            r_starve_cnt <= '0;
        else if ((o_dw_gnt || o_dr_gnt) && r_starve_cnt != '1)
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory shared by fetch, data read and data write; MMIO diversion under MEM_ARBITER_MMIO_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEMSIZE    = 256 * 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_dr_req,
    input  logic [31:0] i_dr_addr,
    output logic        o_dr_gnt,
    output logic        o_dr_rvalid,
    output logic [31:0] o_dr_rdata,
    input  logic        i_dw_req,
    input  logic [31:0] i_dw_addr,
    input  logic [31:0] i_dw_wdata,
    input  logic [3:0]  i_dw_wstrb,
    output logic        o_dw_gnt,
    output logic        o_mem_rready,
    output logic [29:0] o_mem_raddr,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_wready,
    output logic [29:0] o_mem_waddr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    output logic        o_mmio_wvalid,
    output logic [31:0] o_mmio_addr,
    output logic [31:0] o_mmio_wdata,
    output logic        o_stall,
    output logic        o_err
);

    localparam int AW = $clog2(MEMSIZE);

    rsp_src_t    r_rsp_src;
    logic        r_rsp_oob;
    logic        w_rd;
    logic [31:0] w_raddr;
    logic        w_r_oob;
    logic        w_w_oob;
    logic        w_mmio;

    // requests are masked during reset so no grant escapes while resetb is low
    mem_arb_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
        .clk      (clk),
        .resetb   (resetb),
        .i_if_req (i_if_req && resetb),
        .i_dr_req (i_dr_req && resetb),
        .i_dw_req (i_dw_req && resetb),
        .o_if_gnt (o_if_gnt),
        .o_dr_gnt (o_dr_gnt),
        .o_dw_gnt (o_dw_gnt)
    );

    // route the granted access to memory, MMIO or the error pulse; present the pending read response
    always_comb begin
        w_rd          = o_if_gnt || o_dr_gnt;
        w_raddr       = o_dr_gnt ? i_dr_addr : i_if_addr;
        w_r_oob       = (w_raddr >> AW) != 32'd0;
        w_w_oob       = (i_dw_addr >> AW) != 32'd0;
`ifdef MEM_ARBITER_MMIO_EN
        w_mmio        = o_dw_gnt && (i_dw_addr == MEM_PUTC || i_dw_addr == MEM_EXIT);
`else
        w_mmio        = 1'b0;
`endif
        o_mem_rready  = w_rd && !w_r_oob;
        o_mem_raddr   = w_raddr[31:2];
        o_mem_wready  = o_dw_gnt && !w_w_oob;
        o_mem_waddr   = i_dw_addr[31:2];
        o_mem_wdata   = i_dw_wdata;
        o_mem_wstrb   = i_dw_wstrb;
        o_mmio_wvalid = w_mmio;
        o_mmio_addr   = w_mmio ? i_dw_addr : 32'd0;
        o_mmio_wdata  = w_mmio ? i_dw_wdata : 32'd0;
        o_err         = (w_rd && w_r_oob) || (o_dw_gnt && w_w_oob && !w_mmio);
        o_stall       = (i_if_req && !o_if_gnt) || (i_dr_req && !o_dr_gnt) || (i_dw_req && !o_dw_gnt);
        o_if_rvalid   = r_rsp_src == SRC_IF;
        o_dr_rvalid   = r_rsp_src == SRC_DR;
        o_if_rdata    = (o_if_rvalid && !r_rsp_oob) ? i_mem_rdata : 32'd0;
        o_dr_rdata    = (o_dr_rvalid && !r_rsp_oob) ? i_mem_rdata : 32'd0;
    end

    // remember which port owns next cycle's read data and whether it was out of range
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_rsp_src <= SRC_NONE;
            r_rsp_oob <= 1'b0;
        end else begin
            r_rsp_src <= o_dr_gnt ? SRC_DR : (o_if_gnt ? SRC_IF : SRC_NONE);
            r_rsp_oob <= w_r_oob;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, reference memory model and per-cycle output comparison.
module tb_mem_arbiter;

    localparam int MEMSIZE    = 256 * 1024;
    localparam int STARVE_MAX = 4;

    logic        clk, resetb;
    logic        if_req, dr_req, dw_req;
    logic [31:0] if_addr, dr_addr, dw_addr, dw_wdata;
    logic [3:0]  dw_wstrb;
    logic        o_if_gnt, o_if_rvalid, o_dr_gnt, o_dr_rvalid, o_dw_gnt;
    logic [31:0] o_if_rdata, o_dr_rdata;
    logic        o_mem_rready, o_mem_wready, o_mmio_wvalid, o_stall, o_err;
    logic [29:0] o_mem_raddr, o_mem_waddr;
    logic [31:0] o_mem_wdata, o_mmio_addr, o_mmio_wdata, mem_rdata;
    logic [3:0]  o_mem_wstrb;

    logic [31:0] mem   [65536];
    logic [31:0] ref_m [65536];

    int n_tests = 0;
    int n_fail  = 0;

    int          win;
    logic        e_if, e_dr, e_dw, e_rd, e_mm;
    logic [31:0] e_ra;
    int          m_starve;
    int          m_psrc;
    logic [31:0] m_pdata;
    logic [7:0]  gnt_hist;

    mem_arbiter #(.MEMSIZE(MEMSIZE), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetb(resetb),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_dr_req(dr_req), .i_dr_addr(dr_addr),
        .o_dr_gnt(o_dr_gnt), .o_dr_rvalid(o_dr_rvalid), .o_dr_rdata(o_dr_rdata),
        .i_dw_req(dw_req), .i_dw_addr(dw_addr), .i_dw_wdata(dw_wdata), .i_dw_wstrb(dw_wstrb),
        .o_dw_gnt(o_dw_gnt),
        .o_mem_rready(o_mem_rready), .o_mem_raddr(o_mem_raddr), .i_mem_rdata(mem_rdata),
        .o_mem_wready(o_mem_wready), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .o_mmio_wvalid(o_mmio_wvalid), .o_mmio_addr(o_mmio_addr), .o_mmio_wdata(o_mmio_wdata),
        .o_stall(o_stall), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // backing memory: registered read, byte-strobed write
    always @(posedge clk) begin
        if (o_mem_rready) mem_rdata <= mem[o_mem_raddr[15:0]];
        if (o_mem_wready)
            for (int b = 0; b < 4; b++)
                if (o_mem_wstrb[b]) mem[o_mem_waddr[15:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end

    // expected behaviour this cycle, compared against every DUT output
    always @(negedge clk) begin
        if (!resetb)                                   win = 0;
        else if (if_req && m_starve >= STARVE_MAX)     win = 1;
        else if (dw_req)                               win = 3;
        else if (dr_req)                               win = 2;
        else if (if_req)                               win = 1;
        else                                           win = 0;
        e_if = win == 1;
        e_dr = win == 2;
        e_dw = win == 3;
        e_rd = e_if || e_dr;
        e_ra = e_dr ? dr_addr : if_addr;
`ifdef MEM_ARBITER_MMIO_EN
        e_mm = e_dw && (dw_addr == 32'h8000001c || dw_addr == 32'h8000002c);
`else
        e_mm = 1'b0;
`endif
        chk("if_gnt", 32'(o_if_gnt), 32'(e_if));
        chk("dr_gnt", 32'(o_dr_gnt), 32'(e_dr));
        chk("dw_gnt", 32'(o_dw_gnt), 32'(e_dw));
        chk("stall", 32'(o_stall), 32'(resetb && ((if_req && !e_if) || (dr_req && !e_dr) || (dw_req && !e_dw))));
        chk("err", 32'(o_err), 32'((e_rd && e_ra >= 32'(MEMSIZE)) || (e_dw && dw_addr >= 32'(MEMSIZE) && !e_mm)));
        chk("mem_rready", 32'(o_mem_rready), 32'(e_rd && e_ra < 32'(MEMSIZE)));
        if (o_mem_rready) chk("mem_raddr", 32'(o_mem_raddr), e_ra / 4);
        chk("mem_wready", 32'(o_mem_wready), 32'(e_dw && dw_addr < 32'(MEMSIZE)));
        if (o_mem_wready) begin
            chk("mem_waddr", 32'(o_mem_waddr), dw_addr / 4);
            chk("mem_wdata", o_mem_wdata, dw_wdata);
            chk("mem_wstrb", 32'(o_mem_wstrb), 32'(dw_wstrb));
        end
        chk("mmio_wvalid", 32'(o_mmio_wvalid), 32'(e_mm));
`ifdef MEM_ARBITER_MMIO_EN
        if (e_mm) begin
            chk("mmio_addr", o_mmio_addr, dw_addr);
            chk("mmio_wdata", o_mmio_wdata, dw_wdata);
        end
`else
        chk("mmio_addr_tied", o_mmio_addr, 32'd0);
        chk("mmio_wdata_tied", o_mmio_wdata, 32'd0);
`endif
        chk("if_rvalid", 32'(o_if_rvalid), 32'(m_psrc == 1));
        chk("dr_rvalid", 32'(o_dr_rvalid), 32'(m_psrc == 2));
        chk("if_rdata", o_if_rdata, (m_psrc == 1) ? m_pdata : 32'd0);
        chk("dr_rdata", o_dr_rdata, (m_psrc == 2) ? m_pdata : 32'd0);
    end

    // model state: pending response, reference memory contents, fetch wait count
    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_starve <= 0;
            m_psrc   <= 0;
            m_pdata  <= 32'd0;
        end else begin
            m_psrc  <= e_if ? 1 : (e_dr ? 2 : 0);
            m_pdata <= (e_rd && e_ra < 32'(MEMSIZE)) ? ref_m[e_ra[17:2]] : 32'd0;
            if (e_dw && dw_addr < 32'(MEMSIZE))
                for (int b = 0; b < 4; b++)
                    if (dw_wstrb[b]) ref_m[dw_addr[17:2]][8*b +: 8] <= dw_wdata[8*b +: 8];
            if (!if_req || e_if)   m_starve <= 0;
            else if (e_dw || e_dr) m_starve <= m_starve + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 32'd0;
            ref_m[i] = 32'd0;
        end
        mem[16'h40]   = 32'h0000_0013;
        ref_m[16'h40] = 32'h0000_0013;
        mem_rdata = 32'd0;
        resetb = 1'b0;
        if_req = 1'b0; dr_req = 1'b0; dw_req = 1'b0;
        if_addr = 32'd0; dr_addr = 32'd0; dw_addr = 32'd0; dw_wdata = 32'd0; dw_wstrb = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_gnts", {29'd0, o_if_gnt, o_dr_gnt, o_dw_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, o_if_rvalid, o_dr_rvalid}, 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        step();
        resetb = 1'b1;
        // single fetch
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("t1_if_gnt", 32'(o_if_gnt), 32'd1);
        chk("t1_stall", 32'(o_stall), 32'd0);
        step();
        if_req = 1'b0;
        @(negedge clk);
        chk("t1_if_rvalid", 32'(o_if_rvalid), 32'd1);
        chk("t1_if_rdata", o_if_rdata, 32'h0000_0013);
        // write and read of the same word in one cycle
        step();
        dw_req = 1'b1; dw_addr = 32'h200; dw_wdata = 32'hDEAD_BEEF; dw_wstrb = 4'hF;
        dr_req = 1'b1; dr_addr = 32'h200;
        @(negedge clk);
        chk("t2_dw_first", {30'd0, o_dw_gnt, o_dr_gnt}, 32'b10);
        chk("t2_stall", 32'(o_stall), 32'd1);
        step();
        dw_req = 1'b0;
        @(negedge clk);
        chk("t2_dr_gnt", 32'(o_dr_gnt), 32'd1);
        step();
        dr_req = 1'b0;
        @(negedge clk);
        chk("t2_dr_rdata", o_dr_rdata, 32'hDEAD_BEEF);
        // partial-strobe write then read back
        step();
        dw_req = 1'b1; dw_addr = 32'h204; dw_wdata = 32'h1122_3344; dw_wstrb = 4'b0101;
        step();
        dw_req = 1'b0;
        dr_req = 1'b1; dr_addr = 32'h204;
        step();
        dr_req = 1'b0;
        @(negedge clk);
        chk("t2b_strobe_rdata", o_dr_rdata, 32'h0022_0044);
        // fetch starved by continuous data reads
        step();
        if_req = 1'b1; if_addr = 32'h100;
        dr_req = 1'b1; dr_addr = 32'h200;
        gnt_hist = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            gnt_hist[i] = o_if_gnt;
            step();
        end
        chk("t3_fetch_after_4", 32'(gnt_hist), 32'h10);
        if_req = 1'b0; dr_req = 1'b0;
        // out-of-range read
        step();
        dr_req = 1'b1; dr_addr = 32'h0010_0000;
        @(negedge clk);
        chk("t4_oob_gnt_err_rr", {29'd0, o_dr_gnt, o_err, o_mem_rready}, 32'b110);
        step();
        dr_req = 1'b0;
        @(negedge clk);
        chk("t4_oob_rvalid", 32'(o_dr_rvalid), 32'd1);
        chk("t4_oob_rdata", o_dr_rdata, 32'd0);
        // console write
        step();
        dw_req = 1'b1; dw_addr = 32'h8000_001c; dw_wdata = 32'h41; dw_wstrb = 4'hF;
        @(negedge clk);
        chk("t5_dw_gnt", 32'(o_dw_gnt), 32'd1);
        chk("t5_mem_wready", 32'(o_mem_wready), 32'd0);
`ifdef MEM_ARBITER_MMIO_EN
        chk("t5_mmio", {o_mmio_wvalid, o_err, o_mmio_wdata[29:0]}, {2'b10, 30'h41});
`else
        chk("t5_mmio", {o_mmio_wvalid, o_err, o_mmio_wdata[29:0]}, {2'b01, 30'h0});
`endif
        step();
        dw_req = 1'b0;
        // reset right after a read grant discards the response
        step();
        dr_req = 1'b1; dr_addr = 32'h200;
        @(negedge clk);
        chk("t6_dr_gnt", 32'(o_dr_gnt), 32'd1);
        step();
        dr_req = 1'b0;
        resetb = 1'b0;
        @(negedge clk);
        chk("t6_rst_rvalid", {30'd0, o_if_rvalid, o_dr_rvalid}, 32'd0);
        chk("t6_rst_outs", {27'd0, o_mem_rready, o_mem_wready, o_mmio_wvalid, o_err, o_stall}, 32'd0);
        step();
        resetb = 1'b1;
        @(negedge clk);
        chk("t6_post_rvalid", 32'(o_dr_rvalid), 32'd0);
        chk("t6_post_rdata", o_dr_rdata, 32'd0);
        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single backing memory between the IF_ID fetch port and the execute-stage data read and write ports, granting at most one access per cycle. It sits between the core stages and one memmodel instance, replacing the separate imem/dmem pair. It drives a stall back to the core whenever a request is not granted. It optionally diverts console and exit MMIO writes away from memory.

## Interface
- MEMSIZE, 256*1024: backing memory size in bytes (power of two).
- STARVE_MAX, 4: maximum consecutive data grants while fetch waits.
- clk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- if_req / if_addr  in  1/32  fetch read request, byte address
- if_gnt / if_rvalid / if_rdata  out  1/1/32  fetch accepted; data valid next cycle
- dr_req / dr_addr  in  1/32  data read request
- dr_gnt / dr_rvalid / dr_rdata  out  1/1/32  data read accepted; data valid next cycle
- dw_req / dw_addr / dw_wdata / dw_wstrb  in  1/32/32/4  data write request
- dw_gnt  out  1  write accepted (committed at this clock edge)
- mem_rready / mem_raddr  out  1/30  memory read strobe, word address
- mem_rdata  in  32  memory read data, registered, valid one cycle after mem_rready
- mem_wready / mem_waddr / mem_wdata / mem_wstrb  out  1/30/32/4  memory write port
- mmio_wvalid / mmio_addr / mmio_wdata  out  1/32/32  MMIO write strobe (tied 0 without macro)
- stall  out  1  any request present and not granted this cycle
- err  out  1  one-cycle pulse: granted address out of range

## Operation
- Per cycle, one grant. Fixed priority dw > dr > if, except that when starve_cnt == STARVE_MAX and if_req is high, fetch wins.
- starve_cnt (3 bits, saturating): increments on a data grant while if_req is high; clears on a fetch grant or when if_req is low.
- Grants are combinational from the req inputs and the current starve_cnt. mem_* outputs are driven in the grant cycle from the granted address and data; mem_raddr/mem_waddr = addr[31:2].
- Response register rsp_src ∈ {NONE, IF, DR} is loaded with the granted read source. Next cycle, only that source's rvalid is high and its rdata = mem_rdata. The other rdata output holds 0.
- Out of range: addr[31:log2(MEMSIZE)] != 0 and not an MMIO hit. The access is still granted (consumed) but is not forwarded to memory; err pulses in the grant cycle. A read returns rvalid with rdata = 0.
- stall = (if_req & !if_gnt) | (dr_req & !dr_gnt) | (dw_req & !dw_gnt).

## Timing
- Reset values: all gnt/rvalid/mem_*ready/mmio_wvalid/err = 0; rdata = 0; rsp_src = NONE; starve_cnt = 0.
- Read latency 1 cycle (gnt at edge N, rvalid during cycle N+1). Write latency 0 (data in memory after edge N).
- Requesters hold req/addr/data stable until gnt. The arbiter never drops a granted request.
- Write and read to the same word in consecutive cycles: the read sees the new data (write has priority, so it commits first).
- Back-to-back reads: a new read may be granted in the same cycle as the previous rvalid.
- resetb asserted mid-access: the pending response is discarded; no rvalid is emitted after release.

## Configuration
- MEM_ARBITER_MMIO_EN defined: a write to 32'h8000001c (PUTC) or 32'h8000002c (EXIT) is granted and pulses mmio_wvalid with mmio_addr/mmio_wdata. mem_wready stays 0 and err stays 0.
- Undefined: the MMIO outputs are tied 0, and these addresses are treated as ordinary out-of-range writes (err pulses).

## Structure
- Package mem_arb_pkg: rsp_src enum (SRC_NONE, SRC_IF, SRC_DR), MEM_PUTC and MEM_EXIT address constants, starve_cnt width.
- Sub-module mem_arb_sel: priority and starvation selection plus the starve_cnt register, producing one-hot grants.

## Test plan
- Only if_req at 0x100, memory word 0x00000013 → if_gnt at cycle 0; if_rvalid with rdata = 0x00000013 at cycle 1; stall = 0.
- dw_req (0x200, 0xDEADBEEF, strb 0xF) and dr_req (0x200) in the same cycle → dw granted first with dr stalled; dr granted next cycle; dr_rdata = 0xDEADBEEF.
- if_req held high while dr_req stays asserted for 8 cycles → fetch granted after exactly 4 data grants; starve_cnt returns to 0.
- dr_req at 0x00100000 with MEMSIZE 256K → dr_gnt=1, err pulse, mem_rready=0; dr_rvalid next cycle with rdata = 0.
- With MEM_ARBITER_MMIO_EN, dw to 0x8000001c with wdata 0x41 → mmio_wvalid=1, mmio_wdata=0x41, mem_wready=0, err=0.
- resetb low for one cycle right after a dr grant → no dr_rvalid afterwards; all outputs at their reset values.
